// File: rtl/shift_chain_pkg.sv
// Shared types and defaults for the shift-chain sequencer.
//   state_e   : sequencer states
//   DEF_*     : default chain width, requester count, counter width
//   idx_width : bits needed to index n requesters (minimum 1)
package shift_chain_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_NREQ  = 2;
    localparam int unsigned DEF_CNTW  = $clog2(DEF_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_chain_rr_arbiter.sv
// Round-robin arbiter: searches from the pointer for the first valid
// requester, returns a one-hot grant plus its index, and moves the pointer
// past the winner whenever a grant is issued.
//   clk, rst  : clock, synchronous active-high reset
//   en        : arbitration allowed this cycle
//   valid     : per-requester pending flags
//   grant     : one-hot grant (combinational)
//   grant_idx : index of the granted requester (combinational)
module rr_arbiter
    import shift_chain_pkg::*;
#(
    parameter  int unsigned NREQ = DEF_NREQ,
    localparam int unsigned IDW  = idx_width(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] valid,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic [IDW-1:0] ptr;
    logic           found;
    logic [IDW-1:0] cand;

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = IDW'((32'(ptr) + off) % NREQ);
            if (en && !found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Pointer moves to the requester after the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= IDW'((32'(grant_idx) + 1) % NREQ);
        end
    end

endmodule

// File: rtl/shift_chain_ctrl.sv
// Shift-chain sequencer: grants one requester round-robin, shifts its word
// LSB-first (optionally inverted) into the chain, then holds the result until
// the consumer takes it.
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester pending flags
//   req_ready  : per-requester accept strobe (combinational, IDLE only)
//   req_data   : packed request words, slice i = [i*WIDTH +: WIDTH]
//   req_len    : packed bit counts,     slice i = [i*CNTW +: CNTW]
//   req_inv    : per-requester invert-before-chain flag
//   sr_out     : live chain contents
//   busy       : sequencer not idle
//   done_valid : completion pending
//   done_ready : consumer accepts completion
//   done_id    : requester index of the completion
//   done_data  : chain contents at completion
module shift_chain_ctrl
    import shift_chain_pkg::*;
#(
    parameter  int unsigned WIDTH = DEF_WIDTH,
    parameter  int unsigned NREQ  = DEF_NREQ,
    parameter  int unsigned CNTW  = $clog2(WIDTH + 1),
    localparam int unsigned IDW   = idx_width(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ*CNTW-1:0] req_len,
    input  logic [NREQ-1:0]      req_inv,
    output logic [WIDTH-1:0]     sr_out,
    output logic                 busy,
    output logic                 done_valid,
    input  logic                 done_ready,
    output logic [IDW-1:0]       done_id,
    output logic [WIDTH-1:0]     done_data
);

    state_e           state, state_nxt;
    logic [WIDTH-1:0] sr;
    logic [CNTW-1:0]  cnt;
    logic [CNTW-1:0]  len;
    logic [WIDTH-1:0] data;
    logic             inv;
    logic [IDW-1:0]   id;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic             accept;
    logic             arb_en;

    logic [WIDTH-1:0] sel_data;
    logic [CNTW-1:0]  sel_len_raw;
    logic [CNTW-1:0]  sel_len;
    logic             sel_inv;
    logic [WIDTH-1:0] data_shifted;
    logic             bit_in;

    // No grants while in reset, so an accept can never be lost to it.
    assign arb_en = (state == IDLE) && !rst;
    assign accept = |grant;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (arb_en),
        .valid     (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Mux the granted requester's fields; length clamps to the chain width.
    always_comb begin
        sel_data    = '0;
        sel_len_raw = '0;
        sel_inv     = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_data    = req_data[i*WIDTH +: WIDTH];
                sel_len_raw = req_len[i*CNTW +: CNTW];
                sel_inv     = req_inv[i];
            end
        end
        sel_len = (sel_len_raw > CNTW'(WIDTH)) ? CNTW'(WIDTH) : sel_len_raw;
    end

    // Next chain bit: data[cnt], optionally inverted.
    always_comb begin
        data_shifted = data >> cnt;
        bit_in       = data_shifted[0] ^ inv;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (sel_len == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if ((cnt + CNTW'(1)) == len) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state and datapath registers.
    always_comb begin
        req_ready  = grant;
        busy       = (state != IDLE);
        done_valid = (state == DONE);
        done_id    = id;
        done_data  = sr;
        sr_out     = sr;
    end

    // Datapath: latch request on accept, shift one bit per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr   <= '0;
            cnt  <= '0;
            len  <= '0;
            data <= '0;
            inv  <= 1'b0;
            id   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        data <= sel_data;
                        inv  <= sel_inv;
                        id   <= grant_idx;
                        len  <= sel_len;
                        sr   <= '0;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    sr  <= {sr[WIDTH-2:0], bit_in};
                    cnt <= cnt + CNTW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Self-checking bench for shift_chain_ctrl: directed scenarios plus random
// jobs, compared against a bit-reversal reference model and a round-robin
// pointer model kept here.
module tb_shift_chain_ctrl;

    localparam int W    = 32;
    localparam int NR   = 2;
    localparam int CW   = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*W-1:0] req_data;
    logic [NR*CW-1:0] req_len;
    logic [NR-1:0]   req_inv;
    logic [W-1:0]    sr_out;
    logic            busy;
    logic            done_valid;
    logic            done_ready;
    logic [0:0]      done_id;
    logic [W-1:0]    done_data;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ptr  = 0;

    always #5 clk = ~clk;

    shift_chain_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_len    (req_len),
        .req_inv    (req_inv),
        .sr_out     (sr_out),
        .busy       (busy),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .done_id    (done_id),
        .done_data  (done_data)
    );

    // Reference: the first n bits of d end up bit-reversed in the low n bits.
    function automatic logic [W-1:0] model_data(input logic [W-1:0] d, input int l, input logic iv);
        int n;
        logic [W-1:0] r;
        n = (l > W) ? W : l;
        r = '0;
        for (int k = 0; k < n; k++) r[n-1-k] = d[k] ^ iv;
        return r;
    endfunction

    function automatic int model_lat(input int l);
        return ((l > W) ? W : l) + 1;
    endfunction

    // Runs one job on requester idx (call at a negedge with the DUT idle).
    // Returns cycles from accept to first done_valid (-1 on timeout), the
    // completion data/id, and whether outputs held steady while stalled.
    task automatic do_job(input int idx, input logic [W-1:0] d, input int l, input logic iv,
                          input int hold, output logic [W-1:0] got, output int gid,
                          output int lat, output bit stable);
        bit granted;
        granted = 0;
        lat = -1; gid = -1; got = '0; stable = 1;
        req_valid[idx] = 1'b1;
        req_data[idx*W +: W] = d;
        req_len[idx*CW +: CW] = CW'(l);
        req_inv[idx] = iv;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready[idx]) begin
                granted = 1;
                break;
            end
            @(negedge clk);
        end
        if (!granted) begin
            req_valid[idx] = 1'b0;
            return;
        end
        exp_ptr = (idx + 1) % NR;
        @(posedge clk);
        @(negedge clk);
        req_valid[idx] = 1'b0;
        for (int n = 1; n < 100; n++) begin
            if (done_valid) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) return;
        got = done_data;
        gid = int'(done_id);
        if (sr_out !== got) stable = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!done_valid || done_data !== got || sr_out !== got || int'(done_id) != gid)
                stable = 0;
        end
        done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1; req_data = '0; req_len = '0; req_inv = '0; done_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        n_checks++;
        if ({busy, done_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_flags busy/done=%b%b exp=00", busy, done_valid); end
        n_checks++;
        if (sr_out !== '0 || done_id !== 1'b0) begin n_fail++; $display("FAIL reset_regs sr=%h id=%0d exp 0/0", sr_out, done_id); end
        req_valid = '0;
        rst = 1'b0;
        exp_ptr = 0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_req ready=%b busy=%b", req_ready, busy); end
    endtask

    task automatic test_basic();
        logic [W-1:0] got; int gid, lat; bit st;
        do_job(0, 32'h0000_000B, 4, 1'b0, 0, got, gid, lat, st);
        n_checks++;
        if (lat != 5) begin n_fail++; $display("FAIL basic_latency got=%0d exp=5", lat); end
        n_checks++;
        if (got !== 32'h0000_000D || gid != 0) begin n_fail++; $display("FAIL basic_result got=%h id=%0d exp=0000000d id=0", got, gid); end
        n_checks++;
        if (busy !== 1'b0 || done_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle busy=%b dv=%b", busy, done_valid); end
    endtask

    task automatic test_invert_hold();
        logic [W-1:0] got; int gid, lat; bit st;
        do_job(0, 32'h0000_000B, 4, 1'b1, 3, got, gid, lat, st);
        n_checks++;
        if (got !== 32'h0000_0002 || lat != 5) begin n_fail++; $display("FAIL inv_result got=%h lat=%0d exp=00000002 lat=5", got, lat); end
        n_checks++;
        if (st !== 1'b1) begin n_fail++; $display("FAIL inv_hold_stable got=%0d exp=1", st); end
    endtask

    task automatic test_full_len();
        logic [W-1:0] got; int gid, lat; bit st;
        do_job(0, 32'h0000_0001, 32, 1'b0, 0, got, gid, lat, st);
        n_checks++;
        if (got !== 32'h8000_0000 || lat != 33) begin n_fail++; $display("FAIL len32 got=%h lat=%0d exp=80000000 lat=33", got, lat); end
        do_job(0, 32'h0000_0001, 40, 1'b0, 1, got, gid, lat, st);
        n_checks++;
        if (got !== 32'h8000_0000 || lat != 33) begin n_fail++; $display("FAIL len40_clamp got=%h lat=%0d exp=80000000 lat=33", got, lat); end
    endtask

    task automatic test_len_zero();
        logic [W-1:0] got; int gid, lat; bit st;
        do_job(1, 32'hFFFF_FFFF, 0, 1'b1, 1, got, gid, lat, st);
        n_checks++;
        if (got !== '0 || lat != 1 || gid != 1) begin n_fail++; $display("FAIL len0 got=%h lat=%0d id=%0d exp=0 lat=1 id=1", got, lat, gid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL len0_busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d [NR];
        logic [NR-1:0] iv;
        logic [NR-1:0] exp_mask;
        int g;
        d[0] = $urandom; d[1] = $urandom;
        iv = 2'($urandom_range(0, 3));
        req_data = {d[1], d[0]};
        req_len  = {6'd1, 6'd1};
        req_inv  = iv;
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            #1;
            exp_mask = 2'(1 << exp_ptr);
            n_checks++;
            if (req_ready !== exp_mask) begin n_fail++; $display("FAIL rr_grant_%0d got=%b exp=%b", j, req_ready, exp_mask); end
            g = exp_ptr;
            exp_ptr = (exp_ptr + 1) % NR;
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (req_ready !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL rr_shift_%0d ready=%b busy=%b", j, req_ready, busy); end
            @(negedge clk);
            n_checks++;
            if (done_valid !== 1'b1 || int'(done_id) != g || done_data !== model_data(d[g], 1, iv[g]) || req_ready !== 2'b00)
                begin n_fail++; $display("FAIL rr_done_%0d dv=%b id=%0d data=%h ready=%b exp id=%0d data=%h", j, done_valid, done_id, done_data, req_ready, g, model_data(d[g], 1, iv[g])); end
            done_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            done_ready = 1'b0;
        end
        req_valid = 2'b00;
    endtask

    task automatic test_rst_mid();
        logic [W-1:0] got; int gid, lat; bit st, seen;
        logic [W-1:0] d;
        d = $urandom | 32'h1;
        req_data[0 +: W] = d; req_len[0 +: CW] = 6'd8; req_inv[0] = 1'b0; req_valid[0] = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 2'b01 << exp_ptr) begin n_fail++; $display("FAIL rst_mid_grant got=%b", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ptr = 0;
        n_checks++;
        if (sr_out !== '0 || busy !== 1'b0 || done_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_state sr=%h busy=%b dv=%b exp 0/0/0", sr_out, busy, done_valid); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_valid) seen = 1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_done got=%0d exp=0", seen); end
        do_job(1, d, 5, 1'b1, 0, got, gid, lat, st);
        n_checks++;
        if (got !== model_data(d, 5, 1'b1) || lat != 6 || gid != 1) begin n_fail++; $display("FAIL rst_mid_next got=%h lat=%0d id=%0d exp=%h lat=6 id=1", got, lat, gid, model_data(d, 5, 1'b1)); end
    endtask

    task automatic test_random();
        logic [W-1:0] got, d; int gid, lat, idx, l, hold; bit st; logic iv;
        for (int j = 0; j < 16; j++) begin
            idx = $urandom_range(0, NR - 1);
            d = $urandom;
            l = $urandom_range(0, 40);
            iv = 1'($urandom_range(0, 1));
            hold = $urandom_range(0, 3);
            do_job(idx, d, l, iv, hold, got, gid, lat, st);
            n_checks++;
            if (got !== model_data(d, l, iv) || gid != idx) begin n_fail++; $display("FAIL rand_%0d_data got=%h id=%0d exp=%h id=%0d", j, got, gid, model_data(d, l, iv), idx); end
            n_checks++;
            if (lat != model_lat(l) || st !== 1'b1) begin n_fail++; $display("FAIL rand_%0d_timing lat=%0d stable=%0d exp lat=%0d stable=1", j, lat, st, model_lat(l)); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_invert_hold();
        test_full_len();
        test_len_zero();
        test_back_to_back();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
